// File: rtl/flit_unpacker_pkg.sv
// Shared definitions for the flit unpacker: FSM encoding and header format.
package flit_unpacker_pkg;

  typedef enum logic [1:0] {
    StHdr,
    StCollect,
    StEmit
  } state_e;

  // The header flit is the whole payload length; a zero length is illegal.
  localparam int unsigned HdrIllegalLen = 0;

endpackage

// File: rtl/flit_unpacker_if.sv
// FIFO read-side and packed-word output signals of the flit unpacker.
interface flit_unpacker_if #(
  parameter int unsigned FLIT_W         = 4,
  parameter int unsigned FLITS_PER_WORD = 4
);
  localparam int unsigned NfW = $clog2(FLITS_PER_WORD) + 1;

  logic                             fifo_empty;
  logic [FLIT_W-1:0]                fifo_item;
  logic                             fifo_read;
  logic                             out_valid;
  logic                             out_ready;
  logic [FLIT_W*FLITS_PER_WORD-1:0] out_data;
  logic                             out_last;
  logic [NfW-1:0]                   out_nflits;

  modport master (
    output fifo_empty, fifo_item, out_ready,
    input  fifo_read, out_valid, out_data, out_last, out_nflits
  );

  modport slave (
    input  fifo_empty, fifo_item, out_ready,
    output fifo_read, out_valid, out_data, out_last, out_nflits
  );
endinterface

// File: rtl/flit_unpacker.sv
// Pops length-prefixed packets from a show-ahead FIFO and packs the payload
// into FLITS_PER_WORD-flit words on a valid/ready output.
module flit_unpacker
  import flit_unpacker_pkg::*;
#(
  parameter int unsigned FLIT_W         = 4,
  parameter int unsigned FLITS_PER_WORD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  flit_unpacker_if.slave        bus,
  output logic                  hdr_err
);
  localparam int unsigned SlotW = $clog2(FLITS_PER_WORD);
  localparam int unsigned NfW   = SlotW + 1;
  localparam int unsigned WordW = FLIT_W * FLITS_PER_WORD;

  state_e            state_q;
  logic [FLIT_W-1:0] remaining_q;
  logic [SlotW-1:0]  slot_q;
  logic [WordW-1:0]  asm_q;
  logic [WordW-1:0]  asm_next;
  logic [WordW-1:0]  out_data_q;
  logic [NfW-1:0]    out_nflits_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              hdr_err_q;
  logic              pop;

  // Pop depends only on registered state, never on out_ready.
  assign pop = !reset && !bus.fifo_empty && (state_q == StHdr || state_q == StCollect);

  assign bus.fifo_read  = pop;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_nflits = out_nflits_q;
  assign hdr_err        = hdr_err_q;

  always_comb begin
    asm_next = asm_q;
    asm_next[slot_q*FLIT_W +: FLIT_W] = bus.fifo_item;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StHdr;
      remaining_q  <= '0;
      slot_q       <= '0;
      asm_q        <= '0;
      out_data_q   <= '0;
      out_nflits_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      hdr_err_q <= 1'b0;
      unique case (state_q)
        StHdr: begin
          if (pop) begin
            if (bus.fifo_item == FLIT_W'(HdrIllegalLen)) begin
              hdr_err_q <= 1'b1;
            end else begin
              remaining_q <= bus.fifo_item;
              slot_q      <= '0;
              asm_q       <= '0;
              state_q     <= StCollect;
            end
          end
        end
        StCollect: begin
          if (pop) begin
            asm_q       <= asm_next;
            remaining_q <= remaining_q - FLIT_W'(1);
            slot_q      <= slot_q + SlotW'(1);
            if (slot_q == SlotW'(FLITS_PER_WORD - 1) || remaining_q == FLIT_W'(1)) begin
              out_data_q   <= asm_next;
              out_nflits_q <= NfW'(slot_q) + NfW'(1);
              out_last_q   <= (remaining_q == FLIT_W'(1));
              out_valid_q  <= 1'b1;
              state_q      <= StEmit;
            end
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            slot_q      <= '0;
            asm_q       <= '0;
            state_q     <= out_last_q ? StHdr : StCollect;
          end
        end
        default: state_q <= StHdr;
      endcase
    end
  end

endmodule
